// File: rtl/divider_pkg.sv
// Shared types and defaults for the sequential divider.
package divider_pkg;

  localparam int DefaultWidth = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client and seq_divider.
interface seq_divider_if #(
  parameter int Width = divider_pkg::DefaultWidth
) ();

  logic               start;
  logic [2*Width-1:0] data_a;
  logic [Width-1:0]   data_b;
  logic               busy;
  logic               done;
  logic [Width-1:0]   quotient;
  logic [Width-1:0]   remainder;
  logic               div_zero;
  logic               overflow;

  modport master (
    output start, data_a, data_b,
    input  busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, data_a, data_b,
    output busy, done, quotient, remainder, div_zero, overflow
  );

endinterface

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, subtract when it fits.
module div_step #(
  parameter int Width = 16
) (
  input  logic [Width:0]   rem_in,
  input  logic             bit_in,
  input  logic [Width-1:0] divisor,
  output logic [Width:0]   rem_out,
  output logic             q_bit
);

  logic [Width+1:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {2'b00, divisor});
  assign rem_out = (Width+1)'(q_bit ? (shifted - {2'b00, divisor}) : shifted);

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, 2*Width / Width, one quotient bit per cycle.
// Define DIVIDER_SIGNED_EN for two's-complement operands (sign fix-up in DONE).
module seq_divider
  import divider_pkg::*;
#(
  parameter int Width = DefaultWidth
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for start, results held
  // CALC  | one shift-subtract step per cycle, Width cycles
  // DONE  | results and flags registered, done pulses next cycle

  localparam int CntW = $clog2(Width);

  state_e             state_q, state_d;
  logic [Width:0]     rem_q, rem_nxt;
  logic [Width-1:0]   low_q, div_q;
  logic [CntW-1:0]    cnt_q;
  logic               zero_q, ovf_q, done_q, step_bit;
  logic [Width-1:0]   quo_q, rmd_q;
  logic               dz_q, ov_q;
  logic [2*Width-1:0] a_mag;
  logic [Width-1:0]   b_mag;
  logic               zero_c, ovf_c, accept;
  logic [Width-1:0]   res_quo, res_rem;
  logic               res_ov;

`ifdef DIVIDER_SIGNED_EN
  localparam logic [Width-1:0] Half = {1'b1, {(Width-1){1'b0}}};
  logic a_neg, b_neg, neg_quo_q, neg_rem_q;

  assign a_neg = bus.data_a[2*Width-1];
  assign b_neg = bus.data_b[Width-1];
  assign a_mag = a_neg ? -bus.data_a : bus.data_a;
  assign b_mag = b_neg ? -bus.data_b : bus.data_b;
`else
  assign a_mag = bus.data_a;
  assign b_mag = bus.data_b;
`endif

  // Quotient fits only if the upper dividend half is below the divisor.
  assign zero_c = (bus.data_b == '0);
  assign ovf_c  = !zero_c && (a_mag[2*Width-1:Width] >= b_mag);
  assign accept = (state_q == IDLE) && bus.start && !done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (zero_c || ovf_c) ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  div_step #(.Width(Width)) u_step (
    .rem_in  (rem_q),
    .bit_in  (low_q[Width-1]),
    .divisor (div_q),
    .rem_out (rem_nxt),
    .q_bit   (step_bit)
  );

  always_comb begin
    res_quo = '1;
    res_rem = '0;
    res_ov  = 1'b0;
    if (zero_q) begin
      res_rem = low_q;
    end else if (ovf_q) begin
      res_ov = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      if (neg_quo_q ? (low_q > Half) : (low_q >= Half)) begin
        res_ov = 1'b1;
      end else begin
        res_quo = neg_quo_q ? -low_q : low_q;
        res_rem = neg_rem_q ? -rem_q[Width-1:0] : rem_q[Width-1:0];
      end
`else
      res_quo = low_q;
      res_rem = rem_q[Width-1:0];
`endif
    end
  end

  // low_q shifts dividend bits out and quotient bits in; on a zero divisor it keeps the raw low half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      low_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rmd_q  <= '0;
      dz_q   <= 1'b0;
      ov_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      done_q <= (state_q == DONE);
      if (accept) begin
        rem_q  <= {1'b0, a_mag[2*Width-1:Width]};
        low_q  <= zero_c ? bus.data_a[Width-1:0] : a_mag[Width-1:0];
        div_q  <= b_mag;
        cnt_q  <= CntW'(Width - 1);
        zero_q <= zero_c;
        ovf_q  <= ovf_c;
        dz_q   <= 1'b0;
        ov_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
`endif
      end else if (state_q == CALC) begin
        rem_q <= rem_nxt;
        low_q <= {low_q[Width-2:0], step_bit};
        cnt_q <= cnt_q - 1'b1;
      end else if (state_q == DONE) begin
        quo_q <= res_quo;
        rmd_q <= res_rem;
        dz_q  <= zero_q;
        ov_q  <= res_ov;
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;
  assign bus.div_zero  = dz_q;
  assign bus.overflow  = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           dz;
    logic           ov;
    int             lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  seq_divider_if #(.Width(W)) bus ();

  seq_divider #(.Width(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected result straight from the arithmetic definition of the operation.
  function automatic void model(input logic [2*W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov, output int lat);
    longint sa, sb, sq, sr, lo, hi, mag;
`ifdef DIVIDER_SIGNED_EN
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = -(longint'(1) << (W - 1));
    hi = (longint'(1) << (W - 1)) - 1;
`else
    sa = longint'(a);
    sb = longint'(b);
    lo = 0;
    hi = (longint'(1) << W) - 1;
`endif
    q = '1; r = '0; dz = 1'b0; ov = 1'b0; lat = W + 1;
    if (sb == 0) begin
      dz  = 1'b1;
      r   = a[W-1:0];
      lat = 1;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      if (sq < lo || sq > hi) ov = 1'b1;
      else begin
        q = sq[W-1:0];
        r = sr[W-1:0];
      end
      mag = (sq < 0) ? -sq : sq;
      if (mag >= (longint'(1) << W)) lat = 1;
    end
  endfunction

  task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output logic ov, output int lat, output logic one_pulse);
    bus.data_a = a;
    bus.data_b = b;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.data_a = $urandom;
    bus.data_b = W'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus.done !== 1'b1 && lat < 60);
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_zero;
    ov = bus.overflow;
    @(posedge clk); #1;
    one_pulse = (bus.done === 1'b0);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.data_a = '0; bus.data_b = '0;
    #2 rst_n = 1'b0;
    #3;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++;
    if ({bus.quotient, bus.remainder, bus.div_zero, bus.overflow} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got q=%h r=%h dz=%b ov=%b expected all 0",
                              bus.quotient, bus.remainder, bus.div_zero, bus.overflow); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t vecs[$];
    logic [W-1:0] q, r;
    logic dz, ov, p;
    int lat;
    vecs.push_back('{32'h000186A0, 16'h012C, 16'd333,  16'd100,  1'b0, 1'b0, 17});
    vecs.push_back('{32'h00001234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1});
    vecs.push_back('{32'h00100000, 16'h0010, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1});
`ifdef DIVIDER_SIGNED_EN
    vecs.push_back('{32'hFFFE7960, 16'h012C, 16'hFEB3, 16'hFF9C, 1'b0, 1'b0, 17});
`endif
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, q, r, dz, ov, lat, p);
      n_checks++;
      if (lat != vecs[i].lat) begin n_fail++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, vecs[i].lat); end
      n_checks++;
      if ({q, r} !== {vecs[i].q, vecs[i].r})
        begin n_fail++; $display("FAIL directed%0d_result: got q=%h r=%h expected q=%h r=%h", i, q, r, vecs[i].q, vecs[i].r); end
      n_checks++;
      if ({dz, ov} !== {vecs[i].dz, vecs[i].ov})
        begin n_fail++; $display("FAIL directed%0d_flags: got dz=%b ov=%b expected dz=%b ov=%b", i, dz, ov, vecs[i].dz, vecs[i].ov); end
      n_checks++;
      if (p !== 1'b1) begin n_fail++; $display("FAIL directed%0d_pulse: done still high, expected one cycle", i); end
    end
  endtask

  task automatic test_random();
    logic [2*W-1:0] a;
    logic [W-1:0] b, q, r, eq, er;
    logic dz, ov, edz, eov, p;
    int lat, elat;
    for (int i = 0; i < 40; i++) begin
      b = W'($urandom);
      if (i % 8 == 0) b = '0;
      a = $urandom;
      if ($urandom_range(0, 3) != 0 && b != '0) a = {W'($urandom % b), W'($urandom)};
      model(a, b, eq, er, edz, eov, elat);
      run_op(a, b, q, r, dz, ov, lat, p);
      n_checks++;
      if (lat != elat) begin n_fail++; $display("FAIL random%0d_latency: a=%h b=%h got %0d expected %0d", i, a, b, lat, elat); end
      n_checks++;
      if ({q, r, dz, ov} !== {eq, er, edz, eov})
        begin n_fail++; $display("FAIL random%0d_result: a=%h b=%h got q=%h r=%h dz=%b ov=%b expected q=%h r=%h dz=%b ov=%b",
                                i, a, b, q, r, dz, ov, eq, er, edz, eov); end
      n_checks++;
      if (p !== 1'b1) begin n_fail++; $display("FAIL random%0d_pulse: done longer than one cycle", i); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.quotient, bus.remainder, bus.div_zero, bus.overflow} !== {eq, er, edz, eov})
        begin n_fail++; $display("FAIL random%0d_hold: got q=%h r=%h expected q=%h r=%h",
                                i, bus.quotient, bus.remainder, eq, er); end
    end
  endtask

  task automatic test_busy_start();
    logic [W-1:0] eq, er, q, r;
    logic edz, eov;
    int elat, ndone, done_at;
    model(32'h000186A0, 16'h012C, eq, er, edz, eov, elat);
    bus.data_a = 32'h000186A0; bus.data_b = 16'h012C; bus.start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; done_at = -1; q = '0; r = '0;
    for (int c = 1; c <= 30; c++) begin
      bus.start = (c == 3 || c == 10);
      if (bus.start) begin
        bus.data_a = $urandom;
        bus.data_b = W'($urandom_range(1, 16'hFFFF));
      end
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        ndone++; done_at = c; q = bus.quotient; r = bus.remainder;
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (ndone != 1) begin n_fail++; $display("FAIL busy_done_count: got %0d expected 1", ndone); end
    n_checks++;
    if (done_at != elat) begin n_fail++; $display("FAIL busy_latency: got %0d expected %0d", done_at, elat); end
    n_checks++;
    if ({q, r} !== {eq, er}) begin n_fail++; $display("FAIL busy_result: got q=%h r=%h expected q=%h r=%h", q, r, eq, er); end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] a2;
    logic [W-1:0] b2, eq, er;
    logic edz, eov;
    int elat, lat;
    a2 = {W'($urandom_range(0, 16'h0FFF)), W'($urandom)};
    b2 = W'($urandom_range(16'h1000, 16'hFFFF));
    bus.data_a = {W'($urandom_range(0, 16'h00FF)), W'($urandom)};
    bus.data_b = W'($urandom_range(16'h0100, 16'hFFFF));
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (bus.done !== 1'b1 && lat < 60);
    n_checks++;
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1", bus.done); end
    bus.data_a = a2; bus.data_b = b2; bus.start = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done: got busy=%b expected 0", bus.busy); end
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_after_done: got busy=%b expected 1", bus.busy); end
    bus.start = 1'b0;
    model(a2, b2, eq, er, edz, eov, elat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (bus.done !== 1'b1 && lat < 60);
    n_checks++;
    if (lat != elat) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, elat); end
    n_checks++;
    if ({bus.quotient, bus.remainder, bus.div_zero, bus.overflow} !== {eq, er, edz, eov})
      begin n_fail++; $display("FAIL b2b_result: got q=%h r=%h expected q=%h r=%h", bus.quotient, bus.remainder, eq, er); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] a;
    logic [W-1:0] b, q, r, eq, er;
    logic dz, ov, edz, eov, p;
    int lat, elat, ndone;
    bus.data_a = 32'h000186A0; bus.data_b = 16'h012C; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL midreset_busy_done: got %b expected 00", {bus.busy, bus.done}); end
    n_checks++;
    if ({bus.quotient, bus.remainder, bus.div_zero, bus.overflow} !== '0)
      begin n_fail++; $display("FAIL midreset_outputs: got q=%h r=%h expected 0", bus.quotient, bus.remainder); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin @(posedge clk); #1; if (bus.done === 1'b1) ndone++; end
    n_checks++;
    if (ndone != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses expected 0", ndone); end
    b = W'($urandom_range(1, 16'hFFFF));
    a = {W'($urandom % b), W'($urandom)};
    model(a, b, eq, er, edz, eov, elat);
    run_op(a, b, q, r, dz, ov, lat, p);
    n_checks++;
    if (lat != elat) begin n_fail++; $display("FAIL midreset_next_latency: got %0d expected %0d", lat, elat); end
    n_checks++;
    if ({q, r, dz, ov} !== {eq, er, edz, eov})
      begin n_fail++; $display("FAIL midreset_next_result: got q=%h r=%h expected q=%h r=%h", q, r, eq, er); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
